mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: RAM size in 32-bit words, power of two.
REQ-002 Parameter WAIT_STATES, default 2: extra latency cycles per access, range 0..15.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator consumes response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access was misaligned or out of range.
REQ-014 gpio_out  output  8  MMIO output register (see Configuration).

Function
REQ-015 The SHALL FSM have states IDLE, WAIT, ACCESS, RESP; any unused encoding SHALL go to IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid=1 in IDLE.
REQ-017 On acceptance, addr, wdata and write SHALL be latched; later input changes SHALL NOT affect the transaction.
REQ-018 After acceptance the FSM SHALL go to WAIT if WAIT_STATES>0, else directly to ACCESS.
REQ-019 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to ACCESS.
REQ-020 ACCESS SHALL last one cycle: a valid store SHALL write RAM at its closing edge; a valid load SHALL capture RAM data into rsp_rdata.
REQ-021 rsp_valid SHALL go high WAIT_STATES+1 edges after the accepting edge and stay high in RESP until an edge with rsp_ready=1.
REQ-022 rsp_rdata/rsp_err SHALL stay stable while rsp_valid=1.
REQ-023 On the RESP edge with rsp_ready=1 the FSM SHALL return to IDLE; no new request SHALL be accepted on that same edge.
REQ-024 A request with addr[1:0]!=0 SHALL respond with rsp_err=1 and rsp_rdata=0, and SHALL leave RAM unchanged.
REQ-025 A request with word index addr[31:2]>=DEPTH that is not an MMIO hit SHALL respond with rsp_err=1 and rsp_rdata=0, and SHALL leave RAM unchanged.
REQ-026 A store response SHALL carry rsp_rdata=0 and rsp_err=0.

Reset
REQ-027 With reset=1 at an edge: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio_out=0; req_ready=1 after that edge.
REQ-028 Reset in WAIT SHALL abort the transaction without writing RAM; reset in RESP SHALL drop the response.
REQ-029 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With macro MEM_RESPONDER_MMIO_EN defined, address 0xFFFF_FFF0 SHALL be MMIO: a store loads wdata[7:0] into gpio_out; a load returns {24'b0, gpio_out}; rsp_err=0.
REQ-031 Without MEM_RESPONDER_MMIO_EN, gpio_out SHALL be constant 0 and 0xFFFF_FFF0 SHALL be treated as out of range (rsp_err=1).

Structure
REQ-032 Package mem_responder_pkg SHALL hold the FSM state encoding, MMIO_ADDR=32'hFFFF_FFF0, and the 4-bit wait-counter width.
REQ-033 Storage SHALL be a sub-module mem_responder_ram: single-port, synchronous read/write, DEPTH x 32.

Verification
REQ-034 WAIT_STATES=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each rsp_valid 3 edges after acceptance; load returns 0xDEADBEEF, rsp_err=0.
REQ-035 WAIT_STATES=0: load 0x0 -> rsp_valid 1 edge after acceptance; req_ready=0 until RESP completes.
REQ-036 Store to 0x13 -> rsp_err=1, rsp_rdata=0; then load 0x10 still returns prior value.
REQ-037 DEPTH=256: load 0x400 -> rsp_err=1, rsp_rdata=0.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0; rsp_ready=1 -> IDLE on the next edge.
REQ-039 With MMIO_EN: store 0x1A5 to 0xFFFF_FFF0 -> gpio_out=0xA5, load returns 0xA5; assert reset mid-WAIT of a store to 0x20 -> RAM[8] unchanged, gpio_out=0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared definitions for the mem_responder slice.
//   - state_e   : FSM state encoding (IDLE, WAIT, ACCESS, RESP)
//   - CNT_W     : width of the wait-state down-counter
//   - MMIO_ADDR : byte address of the GPIO register (used when the build
//                 defines MEM_RESPONDER_MMIO_EN)
//   - word_in_range() : RAM range test on a byte address
package mem_responder_pkg;

    localparam int          CNT_W     = 4;
    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // True when the word index of a byte address falls inside a RAM of
    // 'depth' words.
    function automatic logic word_in_range(input logic [31:0] addr,
                                           input int unsigned depth);
        return ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between an initiator and the
// memory responder.
//   master : initiator side (drives req_*, rsp_ready)
//   slave  : responder side (drives req_ready, rsp_*)
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port DEPTH x 32 RAM, synchronous write and
// registered read (read data appears one edge after the address).
// Contents are not reset.
//   clk   : clock
//   we    : write enable (writes wdata to addr at the rising edge)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data of addr
module mem_responder_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Storage array: write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait
// states, word-aligned RAM access and error reporting.
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : mem_responder_if.slave request/response handshake
//   gpio_out : MMIO output register
// Build option: define MEM_RESPONDER_MMIO_EN to map a GPIO register at
// MMIO_ADDR; without it gpio_out is tied to zero and that address is out of
// range.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    output logic [7:0]            gpio_out
);

    localparam int AW = $clog2(DEPTH);

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;
    logic               write_r;
    logic               req_ready_r;
    logic               rsp_valid_r;
    logic [31:0]        rsp_rdata_r;
    logic               rsp_err_r;

    logic               err_s;
    logic               mmio_hit_s;
    logic [31:0]        mmio_rdata_s;
    logic               ram_we_s;
    logic [AW-1:0]      ram_addr_s;
    logic [31:0]        ram_rdata_s;

`ifdef MEM_RESPONDER_MMIO_EN
    logic [7:0]         gpio_r;

    // MMIO decode on the latched address.
    always_comb begin
        mmio_hit_s   = (addr_r == MMIO_ADDR);
        mmio_rdata_s = {24'h00_0000, gpio_r};
    end

    // GPIO register: loaded by a store to MMIO_ADDR at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_r <= 8'h00;
        end else if (state_r == ST_ACCESS && write_r && mmio_hit_s) begin
            gpio_r <= wdata_r[7:0];
        end else begin
            gpio_r <= gpio_r;
        end
    end

    assign gpio_out = gpio_r;
`else
    // No MMIO in this build: nothing decodes and the port is tied low.
    always_comb begin
        mmio_hit_s   = 1'b0;
        mmio_rdata_s = 32'h0000_0000;
    end

    assign gpio_out = 8'h00;
`endif

    // Access classification of the latched request. MMIO_ADDR lies far
    // outside any RAM, so it only escapes the range error when decoded.
    always_comb begin
        err_s = (addr_r[1:0] != 2'b00) ||
                (!word_in_range(addr_r, DEPTH) && !mmio_hit_s);
    end

    // RAM port control. While idle the RAM reads the incoming address so a
    // zero-wait-state load has its data ready during ACCESS; afterwards the
    // latched address keeps the read data current. Reset blocks the write.
    always_comb begin
        if (state_r == ST_IDLE) begin
            ram_addr_s = bus.req_addr[AW+1:2];
        end else begin
            ram_addr_s = addr_r[AW+1:2];
        end
        ram_we_s = (state_r == ST_ACCESS) && write_r && !err_s &&
                   !mmio_hit_s && !reset;
    end

    mem_responder_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Main FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            write_r     <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_r      <= bus.req_addr;
                        wdata_r     <= bus.req_wdata;
                        write_r     <= bus.req_write;
                        req_ready_r <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_W'(WAIT_STATES);
                        end else begin
                            state_r <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    // The counter holds the cycles left including this one.
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= ST_ACCESS;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= err_s;
                    if (err_s || write_r) begin
                        rsp_rdata_r <= 32'h0000_0000;
                    end else if (mmio_hit_s) begin
                        rsp_rdata_r <= mmio_rdata_s;
                    end else begin
                        rsp_rdata_r <= ram_rdata_s;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule
